// File: rtl/nand_sequencer_if.sv
// Requester-side bundle for the NAND sequencer: start/done handshake, operands,
// result and NAND-evaluation counter.
interface nand_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] y;
  logic [CNT_W-1:0] nand_count;

  modport master (
    output start, op, a, b,
    input  busy, done, err, y, nand_count
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, err, y, nand_count
  );
endinterface

// File: rtl/nand_sequencer.sv
// Evaluates a two-input bitwise function by time-multiplexing one WIDTH-bit NAND
// stage over a per-operation micro-sequence, with scratch registers between steps.
module nand_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  nand_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, ERR} state_t;

  localparam logic [2:0] OP_NAND = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  // Destination of the current NAND step: result register or one scratch word.
  localparam logic [2:0] DST_Y  = 3'd0;
  localparam logic [2:0] DST_W1 = 3'd1;
  localparam logic [2:0] DST_W2 = 3'd2;
  localparam logic [2:0] DST_W3 = 3'd3;
  localparam logic [2:0] DST_W4 = 3'd4;

  state_t           state_reg;
  logic [2:0]       op_reg;
  logic [2:0]       step_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] w1_reg;
  logic [WIDTH-1:0] w2_reg;
  logic [WIDTH-1:0] w3_reg;
  logic [WIDTH-1:0] w4_reg;
  logic [WIDTH-1:0] y_reg;
  logic             done_reg;
  logic             err_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [WIDTH-1:0] nand_x;
  logic [WIDTH-1:0] nand_z;
  logic [WIDTH-1:0] nand_out;
  logic [2:0]       dst;
  logic             last;

  // Operand routing for the shared stage; anything not listed is the final y step.
  always_comb begin
    nand_x = a_reg;
    nand_z = b_reg;
    dst    = DST_Y;
    last   = 1'b1;
    case (op_reg)
      OP_NOT: nand_z = a_reg;
      OP_AND: begin
        case (step_reg)
          3'd0:    begin dst = DST_W1; last = 1'b0; end
          default: begin nand_x = w1_reg; nand_z = w1_reg; end
        endcase
      end
      OP_OR, OP_NOR: begin
        case (step_reg)
          3'd0: begin nand_z = a_reg; dst = DST_W1; last = 1'b0; end
          3'd1: begin nand_x = b_reg; dst = DST_W2; last = 1'b0; end
          3'd2: begin
            nand_x = w1_reg;
            nand_z = w2_reg;
            if (op_reg == OP_NOR) begin
              dst  = DST_W3;
              last = 1'b0;
            end
          end
          default: begin nand_x = w3_reg; nand_z = w3_reg; end
        endcase
      end
      OP_XOR, OP_XNOR: begin
        case (step_reg)
          3'd0: begin dst = DST_W1; last = 1'b0; end
          3'd1: begin nand_z = w1_reg; dst = DST_W2; last = 1'b0; end
          3'd2: begin nand_x = b_reg; nand_z = w1_reg; dst = DST_W3; last = 1'b0; end
          3'd3: begin
            nand_x = w2_reg;
            nand_z = w3_reg;
            if (op_reg == OP_XNOR) begin
              dst  = DST_W4;
              last = 1'b0;
            end
          end
          default: begin nand_x = w4_reg; nand_z = w4_reg; end
        endcase
      end
      default: ;
    endcase
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_nand
      assign nand_out[gi] = ~(nand_x[gi] & nand_z[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      op_reg    <= '0;
      step_reg  <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      w1_reg    <= '0;
      w2_reg    <= '0;
      w3_reg    <= '0;
      w4_reg    <= '0;
      y_reg     <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            op_reg    <= bus.op;
            step_reg  <= '0;
            state_reg <= (bus.op == OP_ILL) ? ERR : EXEC;
          end
        end
        EXEC: begin
          case (dst)
            DST_W1:  w1_reg <= nand_out;
            DST_W2:  w2_reg <= nand_out;
            DST_W3:  w3_reg <= nand_out;
            DST_W4:  w4_reg <= nand_out;
            default: y_reg  <= nand_out;
          endcase
          if (cnt_reg != '1) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
          step_reg <= step_reg + 3'd1;
          if (last) begin
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        ERR: begin
          done_reg  <= 1'b1;
          err_reg   <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy       = (state_reg != IDLE);
  assign bus.done       = done_reg;
  assign bus.err        = err_reg;
  assign bus.y          = y_reg;
  assign bus.nand_count = cnt_reg;

endmodule
